// File: rtl/pipe_hazard_unit.sv
// Scoreboard-based hazard detection and operand forwarding at the register-read stage.
// Define PIPE_HAZ_FWD_EN to enable forwarding; otherwise every dependency stalls until retirement.
module pipe_hazard_unit #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned REG_AW   = 3,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_RDY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hold,
    input  logic                    flush,
    input  logic                    iss_valid,
    input  logic                    iss_wr,
    input  logic                    iss_load,
    input  logic [REG_AW-1:0]       iss_dest,
    input  logic [REG_AW-1:0]       src_a,
    input  logic [REG_AW-1:0]       src_b,
    input  logic                    src_a_used,
    input  logic                    src_b_used,
    input  logic [DATA_W-1:0]       rf_a,
    input  logic [DATA_W-1:0]       rf_b,
    input  logic [DEPTH*DATA_W-1:0] stage_data,
    output logic                    stall,
    output logic [DEPTH:0]          fwd_sel_a,
    output logic [DEPTH:0]          fwd_sel_b,
    output logic [DATA_W-1:0]       opnd_a,
    output logic [DATA_W-1:0]       opnd_b
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic              v;
        logic              wr;
        logic              load;
        logic [REG_AW-1:0] dest;
    } sb_entry_t;

    sb_entry_t         sb_q [DEPTH];
    sb_entry_t         new_entry;

    logic [REG_AW-1:0] src      [2];
    logic              src_used [2];
    logic [DATA_W-1:0] rf_data  [2];
    logic              hit      [2];
    logic [IDX_W-1:0]  win_idx  [2];
    logic              hazard   [2];
    logic [DEPTH:0]    sel      [2];
    logic [DATA_W-1:0] opnd     [2];

    assign src[0]      = src_a;
    assign src[1]      = src_b;
    assign src_used[0] = src_a_used;
    assign src_used[1] = src_b_used;
    assign rf_data[0]  = rf_a;
    assign rf_data[1]  = rf_b;

    // Youngest matching writer wins: scan oldest to youngest so the last hit overrides.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            hit[s]     = 1'b0;
            win_idx[s] = '0;
            for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
                if (sb_q[i].v && sb_q[i].wr && src_used[s] && (sb_q[i].dest == src[s])) begin
                    hit[s]     = 1'b1;
                    win_idx[s] = IDX_W'(i);
                end
            end
        end
    end

`ifdef PIPE_HAZ_FWD_EN
    logic [DATA_W-1:0] slice [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_slice
        assign slice[g] = stage_data[g*DATA_W +: DATA_W];
    end

    // A load still in flight before LOAD_RDY cannot forward; anything else forwards its stage result.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            hazard[s] = hit[s] && sb_q[win_idx[s]].load && (32'(win_idx[s]) < LOAD_RDY);
            sel[s]    = '0;
            opnd[s]   = rf_data[s];
            if (hit[s] && !hazard[s]) begin
                opnd[s] = slice[win_idx[s]];
                for (int i = 0; i < int'(DEPTH); i++) begin
                    sel[s][i+1] = (win_idx[s] == IDX_W'(i));
                end
            end else begin
                sel[s][0] = 1'b1;
            end
        end
    end
`else
    logic [DEPTH-1:0] load_bits;
    logic             unused_fwd;

    // Without forwarding, any pending writer blocks the read until it reaches the register file.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            hazard[s] = hit[s];
            sel[s]    = '0;
            sel[s][0] = 1'b1;
            opnd[s]   = rf_data[s];
        end
    end

    always_comb begin
        load_bits = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            load_bits[i] = sb_q[i].load;
        end
    end

    assign unused_fwd = ^{stage_data, load_bits, win_idx[0], win_idx[1]};
`endif

    assign stall     = iss_valid && !flush && (hazard[0] || hazard[1]);
    assign fwd_sel_a = sel[0];
    assign fwd_sel_b = sel[1];
    assign opnd_a    = opnd[0];
    assign opnd_b    = opnd[1];

    always_comb begin
        new_entry = '0;
        if (iss_valid && !stall && !flush) begin
            new_entry = {1'b1, iss_wr, iss_load, iss_dest};
        end
    end

    // Scoreboard shift: entry 0 takes the issuing instruction or a bubble, the last entry retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                sb_q[i] <= '0;
            end
        end else if (!hold) begin
            sb_q[0] <= new_entry;
            for (int i = 1; i < int'(DEPTH); i++) begin
                sb_q[i] <= sb_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: directed hazard scenarios plus randomized traffic
// checked against an instruction-history reference model.
module tb_pipe_hazard_unit;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned REG_AW   = 3;
    localparam int unsigned DEPTH    = 3;
    localparam int unsigned LOAD_RDY = 1;
`ifdef PIPE_HAZ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst, hold, flush;
    logic                    iss_valid, iss_wr, iss_load;
    logic [REG_AW-1:0]       iss_dest, src_a, src_b;
    logic                    src_a_used, src_b_used;
    logic [DATA_W-1:0]       rf_a, rf_b;
    logic [DEPTH*DATA_W-1:0] stage_data;
    logic                    stall;
    logic [DEPTH:0]          fwd_sel_a, fwd_sel_b;
    logic [DATA_W-1:0]       opnd_a, opnd_b;

    int errors = 0;
    int checks = 0;
    bit exp_stall;
    int n;

    typedef struct {
        bit              v;
        bit              wr;
        bit              load;
        bit [REG_AW-1:0] dest;
    } rec_t;

    // hist[k] is the instruction issued k cycles ago that is still in flight (k = 0 is youngest).
    rec_t hist[$];

    pipe_hazard_unit #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_RDY(LOAD_RDY)
    ) dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_load(iss_load), .iss_dest(iss_dest),
        .src_a(src_a), .src_b(src_b), .src_a_used(src_a_used), .src_b_used(src_b_used),
        .rf_a(rf_a), .rf_b(rf_b), .stage_data(stage_data),
        .stall(stall), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .opnd_a(opnd_a), .opnd_b(opnd_b)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        rec_t b = '{v: 1'b0, wr: 1'b0, load: 1'b0, dest: '0};
        hist.delete();
        for (int i = 0; i < int'(DEPTH); i++) hist.push_back(b);
    endfunction

    function automatic void model_src(input bit [REG_AW-1:0] s, input bit used,
                                      input bit [DATA_W-1:0] rf, input bit [DEPTH*DATA_W-1:0] sd,
                                      output bit haz, output bit [DEPTH:0] sel,
                                      output bit [DATA_W-1:0] val);
        int age = -1;
        bit [DEPTH:0] one = 1;
        foreach (hist[k]) begin
            if (age < 0 && used && hist[k].v && hist[k].wr && hist[k].dest == s) age = k;
        end
        haz = 1'b0;
        sel = one;
        val = rf;
        if (age >= 0) begin
            if (!FWD || (hist[age].load && age < int'(LOAD_RDY))) begin
                haz = 1'b1;
            end else begin
                sel = one << (age + 1);
                val = DATA_W'(sd >> (age * int'(DATA_W)));
            end
        end
    endfunction

    task automatic idle();
        rst = 0; hold = 0; flush = 0;
        iss_valid = 0; iss_wr = 0; iss_load = 0; iss_dest = '0;
        src_a = '0; src_b = '0; src_a_used = 0; src_b_used = 0;
    endtask

    // Called just after a falling edge with inputs applied: compare all outputs to the model.
    task automatic eval_now();
        bit ha, hb;
        bit [DEPTH:0] sa, sb;
        bit [DATA_W-1:0] va, vb;
        #1;
        model_src(src_a, src_a_used, rf_a, stage_data, ha, sa, va);
        model_src(src_b, src_b_used, rf_b, stage_data, hb, sb, vb);
        exp_stall = iss_valid && !flush && (ha || hb);
        check_eq("stall", 32'(stall), 32'(exp_stall));
        check_eq("fwd_sel_a", 32'(fwd_sel_a), 32'(sa));
        check_eq("fwd_sel_b", 32'(fwd_sel_b), 32'(sb));
        check_eq("opnd_a", 32'(opnd_a), 32'(va));
        check_eq("opnd_b", 32'(opnd_b), 32'(vb));
    endtask

    task automatic tick();
        rec_t r;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (!hold) begin
            r = '{v: iss_valid && !exp_stall && !flush, wr: iss_wr, load: iss_load, dest: iss_dest};
            hist.push_front(r);
            void'(hist.pop_back());
        end
        @(negedge clk);
    endtask

    task automatic issue(input bit wr, input bit ld, input bit [REG_AW-1:0] d);
        idle();
        iss_valid = 1; iss_wr = wr; iss_load = ld; iss_dest = d;
        eval_now();
        tick();
    endtask

    task automatic drain();
        idle();
        repeat (DEPTH + 1) begin
            eval_now();
            tick();
        end
    endtask

    // Count stall cycles for the instruction currently in RR, bounded so a stuck stall still ends.
    task automatic count_stalls(output int cnt);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            eval_now();
            if (!stall) break;
            cnt++;
            tick();
        end
    endtask

    initial begin
        idle();
        rf_a = 16'hbeef; rf_b = 16'hcafe; stage_data = '0;
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        rst = 0;

        // Reset state
        eval_now();
        check_eq("rst_stall", 32'(stall), 32'(0));
        check_eq("rst_sel_a", 32'(fwd_sel_a), 32'(1));
        check_eq("rst_sel_b", 32'(fwd_sel_b), 32'(1));
        check_eq("rst_opnd_a", 32'(opnd_a), 32'(rf_a));
        check_eq("rst_opnd_b", 32'(opnd_b), 32'(rf_b));

        // Back-to-back ALU dependency
        issue(1, 0, 3'd1);
        idle();
        iss_valid = 1; src_a = 3'd1; src_a_used = 1;
        stage_data = {16'h0000, 16'h0000, 16'h1234};
        count_stalls(n);
        check_eq("alu_stall_cycles", 32'(n), FWD ? 32'(0) : 32'(DEPTH));
        check_eq("alu_sel_a", 32'(fwd_sel_a), FWD ? 32'(2) : 32'(1));
        check_eq("alu_opnd_a", 32'(opnd_a), FWD ? 32'(16'h1234) : 32'(rf_a));
        tick();
        drain();

        // Load-use
        issue(1, 1, 3'd3);
        idle();
        iss_valid = 1; src_b = 3'd3; src_b_used = 1;
        stage_data = {16'h0000, 16'h5678, 16'h1111};
        count_stalls(n);
        check_eq("lu_stall_cycles", 32'(n), FWD ? 32'(LOAD_RDY) : 32'(DEPTH));
        check_eq("lu_sel_b", 32'(fwd_sel_b), FWD ? 32'(4) : 32'(1));
        check_eq("lu_opnd_b", 32'(opnd_b), FWD ? 32'(16'h5678) : 32'(rf_b));
        tick();
        drain();

        // Two writers of r2, youngest must win
        issue(1, 0, 3'd2);
        issue(1, 0, 3'd2);
        idle();
        iss_valid = 1; src_a = 3'd2; src_a_used = 1;
        stage_data = {16'h0000, 16'h2222, 16'h3333};
        eval_now();
        check_eq("dup_stall", 32'(stall), FWD ? 32'(0) : 32'(1));
        check_eq("dup_sel_a", 32'(fwd_sel_a), FWD ? 32'(2) : 32'(1));
        check_eq("dup_opnd_a", 32'(opnd_a), FWD ? 32'(16'h3333) : 32'(rf_a));
        tick();
        drain();

        // Flush during a load-use stall
        issue(1, 1, 3'd3);
        idle();
        iss_valid = 1; src_b = 3'd3; src_b_used = 1; flush = 1;
        eval_now();
        check_eq("flush_stall", 32'(stall), 32'(0));
        tick();
        flush = 0;
        eval_now();
        check_eq("post_flush_stall", 32'(stall), FWD ? 32'(0) : 32'(1));
        tick();
        drain();

        // Hold during a load-use stall
        issue(1, 1, 3'd3);
        idle();
        iss_valid = 1; src_b = 3'd3; src_b_used = 1; hold = 1;
        repeat (4) begin
            eval_now();
            check_eq("hold_stall", 32'(stall), 32'(1));
            tick();
        end
        hold = 0;
        count_stalls(n);
        check_eq("hold_release_cycles", 32'(n), FWD ? 32'(LOAD_RDY) : 32'(DEPTH));
        tick();
        drain();

        // Reset with a full scoreboard
        issue(1, 0, 3'd1);
        issue(1, 1, 3'd2);
        issue(1, 0, 3'd3);
        idle();
        rst = 1;
        eval_now();
        tick();
        idle();
        iss_valid = 1; src_a = 3'd1; src_a_used = 1; src_b = 3'd2; src_b_used = 1;
        eval_now();
        check_eq("post_rst_stall", 32'(stall), 32'(0));
        check_eq("post_rst_sel_a", 32'(fwd_sel_a), 32'(1));
        check_eq("post_rst_sel_b", 32'(fwd_sel_b), 32'(1));
        tick();
        drain();

        // Randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            rst        = ($urandom_range(0, 63) == 0);
            hold       = ($urandom_range(0, 7) == 0);
            flush      = ($urandom_range(0, 7) == 0);
            iss_valid  = ($urandom_range(0, 3) != 0);
            iss_wr     = ($urandom_range(0, 3) != 0);
            iss_load   = ($urandom_range(0, 2) == 0);
            iss_dest   = REG_AW'($urandom_range(0, 3));
            src_a      = REG_AW'($urandom_range(0, 3));
            src_b      = REG_AW'($urandom_range(0, 3));
            src_a_used = ($urandom_range(0, 3) != 0);
            src_b_used = ($urandom_range(0, 3) != 0);
            rf_a       = DATA_W'($urandom);
            rf_b       = DATA_W'($urandom);
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            end
            eval_now();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
